// File: rtl/sentry_pkg.sv
// -----------------------------------------------------------------------------
// sentry_pkg
// Shared definitions for the secure-boot measurement controller:
//   - controller state encoding
//   - failure codes reported on O_sysctl_fail_code
//   - AHB-Lite HTRANS / HBURST / HPROT constants
//   - helper that turns the data width into an HSIZE value
// No ports; imported by sentry_boot_ctrl and sentry_digest_acc.
// -----------------------------------------------------------------------------
package sentry_pkg;

  // Controller states, in the order a normal boot walks through them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } state_e;

  // Reason reported when the measurement stops early.
  typedef enum logic [1:0] {
    FAIL_NONE    = 2'b00,
    FAIL_DIGEST  = 2'b01,
    FAIL_BUS     = 2'b10,
    FAIL_TIMEOUT = 2'b11
  } fail_code_e;

  // AHB-Lite transfer type and burst encodings used by this manager.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Privileged data access.
  localparam logic [3:0] HPROT_PRIV_DATA = 4'b0011;

  // The region lookup tables are always sized for the largest supported
  // region count so that a 4-bit region index addresses them exactly.
  localparam int unsigned MAX_REGIONS = 16;

  // HSIZE is log2 of the transfer size in bytes: 4 bytes -> 2, 8 bytes -> 3.
  function automatic logic [2:0] hsize_for(input int unsigned data_w);
    return (data_w == 64) ? 3'd3 : 3'd2;
  endfunction

endpackage

// File: rtl/sentry_digest_acc.sv
// -----------------------------------------------------------------------------
// sentry_digest_acc
// Running digest of one boot region: seeded with the device ID at the start of
// each region, folded with every read word as rotate-left-by-1 then XOR, and
// compared against the expected digest for that region.
// Ports:
//   clk_in, rst   clock and synchronous active-high reset
//   seed_en/seed  load the accumulator with the seed (takes priority)
//   upd_en/rdata  fold one bus word into the accumulator
//   expected      expected digest of the region being measured
//   acc           current accumulator value
//   match         acc equals expected
// -----------------------------------------------------------------------------
module sentry_digest_acc
  import sentry_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              seed_en,
  input  logic [DATA_W-1:0] seed,
  input  logic              upd_en,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] expected,
  output logic [DATA_W-1:0] acc,
  output logic              match
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;

  // Seeding wins over folding so a new region always starts from the
  // device ID even if a stray update strobe coincides with it.
  always_comb begin
    acc_d = acc_q;
    if (seed_en) begin
      acc_d = seed;
    end else if (upd_en) begin
      acc_d = {acc_q[DATA_W-2:0], acc_q[DATA_W-1]} ^ rdata;
    end
  end

  // Accumulator register, cleared by reset like every other counter.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc   = acc_q;
  assign match = (acc_q == expected);

endmodule

// File: rtl/sentry_boot_ctrl.sv
// -----------------------------------------------------------------------------
// sentry_boot_ctrl
// Secure-boot measurement controller. When the device ID becomes valid it reads
// every boot region over AHB-Lite (single, non-pipelined word reads), folds the
// words into a per-region digest and compares each digest with the expected
// value. The verdict is reported on sticky done/pass/fail outputs until reset.
//
// Ports:
//   clk_in, rst                 clock, synchronous active-high reset
//   I_did_hw_devid/_valid       device ID and start trigger
//   I_rgn_base/_words/_digest   packed per-region base, word count, digest
//   sys_ctrl_h*                 AHB-Lite manager interface (read only)
//   O_sysctl_secure_boot_done   measurement finished (pass or fail)
//   O_sysctl_secure_boot_pass   all regions matched
//   O_sysctl_fail_code          00 none, 01 digest, 10 bus error, 11 timeout
//   O_sysctl_fail_region        region index at failure
//
// Build option: define SENTRY_BOOT_TIMEOUT_EN to add a wait-state watchdog
// that fails the boot after TIMEOUT_CYC consecutive hready=0 cycles.
// -----------------------------------------------------------------------------
module sentry_boot_ctrl
  import sentry_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int DEVID_W     = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk_in,
  input  logic                          rst,
  input  logic [DEVID_W-1:0]            I_did_hw_devid,
  input  logic                          I_did_hw_valid,
  input  logic [NUM_REGIONS*ADDR_W-1:0] I_rgn_base,
  input  logic [NUM_REGIONS*LEN_W-1:0]  I_rgn_words,
  input  logic [NUM_REGIONS*DATA_W-1:0] I_rgn_digest,
  output logic                          sys_ctrl_hclk_out,
  output logic [ADDR_W-1:0]             sys_ctrl_haddr,
  output logic [2:0]                    sys_ctrl_hburst,
  output logic                          sys_ctrl_hmastlock,
  output logic [3:0]                    sys_ctrl_hprot,
  output logic                          sys_ctrl_hnonsec,
  output logic [2:0]                    sys_ctrl_hsize,
  output logic [1:0]                    sys_ctrl_htrans,
  output logic [DATA_W-1:0]             sys_ctrl_hwdata,
  output logic                          sys_ctrl_hwrite,
  input  logic [DATA_W-1:0]             sys_ctrl_hrdata,
  input  logic                          sys_ctrl_hready,
  input  logic                          sys_ctrl_hresp,
  output logic                          O_sysctl_secure_boot_done,
  output logic                          O_sysctl_secure_boot_pass,
  output logic [1:0]                    O_sysctl_fail_code,
  output logic [3:0]                    O_sysctl_fail_region
);

  localparam logic [ADDR_W-1:0] ADDR_STEP   = ADDR_W'(DATA_W / 8);
  localparam logic [3:0]        LAST_REGION = 4'(NUM_REGIONS - 1);
  localparam logic [2:0]        HSIZE       = hsize_for(DATA_W);

  state_e            state_q, state_d;
  logic [3:0]        region_q, region_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  words_q, words_d;
  logic [DATA_W-1:0] devid_q, devid_d;
  logic              pass_q, pass_d;
  fail_code_e        fail_code_q, fail_code_d;
  logic [3:0]        fail_region_q, fail_region_d;

  logic [DATA_W-1:0] devid_ext;
  logic [3:0]        next_region;
  logic [1:0]        htrans_c;
  logic              seed_en;
  logic [DATA_W-1:0] seed_val;
  logic              upd_en;
  logic [DATA_W-1:0] acc;
  logic              digest_match;

  logic [ADDR_W-1:0] base_tbl   [MAX_REGIONS];
  logic [LEN_W-1:0]  words_tbl  [MAX_REGIONS];
  logic [DATA_W-1:0] digest_tbl [MAX_REGIONS];

  // Unpack the region buses into full-size tables; unused entries read as
  // zero so the 4-bit region index never selects outside the table.
  for (genvar g = 0; g < MAX_REGIONS; g++) begin : g_tbl
    if (g < NUM_REGIONS) begin : g_used
      assign base_tbl[g]   = I_rgn_base[g*ADDR_W +: ADDR_W];
      assign words_tbl[g]  = I_rgn_words[g*LEN_W +: LEN_W];
      assign digest_tbl[g] = I_rgn_digest[g*DATA_W +: DATA_W];
    end else begin : g_unused
      assign base_tbl[g]   = '0;
      assign words_tbl[g]  = '0;
      assign digest_tbl[g] = '0;
    end
  end

  // The device ID seeds a DATA_W-wide accumulator: zero-extend a narrow ID,
  // keep the low bits of a wide one.
  if (DEVID_W >= DATA_W) begin : g_devid_trunc
    assign devid_ext = I_did_hw_devid[DATA_W-1:0];
  end else begin : g_devid_zext
    assign devid_ext = {{(DATA_W - DEVID_W){1'b0}}, I_did_hw_devid};
  end

`ifdef SENTRY_BOOT_TIMEOUT_EN
  localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign next_region = region_q + 4'd1;

  // Next-state and datapath control. Each region goes through ADDR/DATA once
  // per word (skipped entirely when its length is zero), then spends one
  // cycle in CHECK. DONE and FAIL hold until reset.
  always_comb begin
    state_d       = state_q;
    region_d      = region_q;
    addr_d        = addr_q;
    words_d       = words_q;
    devid_d       = devid_q;
    pass_d        = pass_q;
    fail_code_d   = fail_code_q;
    fail_region_d = fail_region_q;
    seed_en       = 1'b0;
    seed_val      = devid_q;
    upd_en        = 1'b0;
    htrans_c      = HTRANS_IDLE;
`ifdef SENTRY_BOOT_TIMEOUT_EN
    tmo_d         = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (I_did_hw_valid) begin
          devid_d  = devid_ext;
          region_d = 4'd0;
          addr_d   = base_tbl[0];
          words_d  = words_tbl[0];
          seed_en  = 1'b1;
          seed_val = devid_ext;
          state_d  = (words_tbl[0] == '0) ? ST_CHECK : ST_ADDR;
        end
      end

      ST_ADDR: begin
        htrans_c = HTRANS_NONSEQ;
        if (sys_ctrl_hready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        // An error response ends the boot immediately, even mid wait-state.
        if (sys_ctrl_hresp) begin
          state_d       = ST_FAIL;
          fail_code_d   = FAIL_BUS;
          fail_region_d = region_q;
        end else if (sys_ctrl_hready) begin
          upd_en  = 1'b1;
          addr_d  = addr_q + ADDR_STEP;
          words_d = words_q - LEN_W'(1);
          state_d = (words_q == LEN_W'(1)) ? ST_CHECK : ST_ADDR;
        end
      end

      ST_CHECK: begin
        if (!digest_match) begin
          state_d       = ST_FAIL;
          fail_code_d   = FAIL_DIGEST;
          fail_region_d = region_q;
        end else if (region_q == LAST_REGION) begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end else begin
          region_d = next_region;
          addr_d   = base_tbl[next_region];
          words_d  = words_tbl[next_region];
          seed_en  = 1'b1;
          state_d  = (words_tbl[next_region] == '0) ? ST_CHECK : ST_ADDR;
        end
      end

      ST_DONE, ST_FAIL: begin
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef SENTRY_BOOT_TIMEOUT_EN
    // Watchdog over consecutive wait states; a bus error reported in the same
    // cycle keeps priority over the timeout.
    if (((state_q == ST_ADDR) || (state_q == ST_DATA)) && !sys_ctrl_hready) begin
      tmo_d = tmo_q + TMO_W'(1);
      if ((tmo_d == TMO_LIMIT) && !((state_q == ST_DATA) && sys_ctrl_hresp)) begin
        state_d       = ST_FAIL;
        fail_code_d   = FAIL_TIMEOUT;
        fail_region_d = region_q;
        upd_en        = 1'b0;
      end
    end
`endif
  end

  // State and bookkeeping registers; reset returns everything to the idle,
  // no-verdict condition even in the middle of a transfer.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      region_q      <= '0;
      addr_q        <= '0;
      words_q       <= '0;
      devid_q       <= '0;
      pass_q        <= 1'b0;
      fail_code_q   <= FAIL_NONE;
      fail_region_q <= '0;
`ifdef SENTRY_BOOT_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      region_q      <= region_d;
      addr_q        <= addr_d;
      words_q       <= words_d;
      devid_q       <= devid_d;
      pass_q        <= pass_d;
      fail_code_q   <= fail_code_d;
      fail_region_q <= fail_region_d;
`ifdef SENTRY_BOOT_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  sentry_digest_acc #(
    .DATA_W (DATA_W)
  ) u_digest (
    .clk_in   (clk_in),
    .rst      (rst),
    .seed_en  (seed_en),
    .seed     (seed_val),
    .upd_en   (upd_en),
    .rdata    (sys_ctrl_hrdata),
    .expected (digest_tbl[region_q]),
    .acc      (acc),
    .match    (digest_match)
  );

  assign sys_ctrl_hclk_out  = clk_in;
  assign sys_ctrl_haddr     = addr_q;
  assign sys_ctrl_htrans    = htrans_c;
  assign sys_ctrl_hburst    = HBURST_SINGLE;
  assign sys_ctrl_hsize     = HSIZE;
  assign sys_ctrl_hprot     = HPROT_PRIV_DATA;
  assign sys_ctrl_hwrite    = 1'b0;
  assign sys_ctrl_hwdata    = '0;
  assign sys_ctrl_hmastlock = 1'b0;
  assign sys_ctrl_hnonsec   = 1'b0;

  assign O_sysctl_secure_boot_done = (state_q == ST_DONE) || (state_q == ST_FAIL);
  assign O_sysctl_secure_boot_pass = pass_q;
  assign O_sysctl_fail_code        = fail_code_q;
  assign O_sysctl_fail_region      = fail_region_q;

endmodule

// File: tb/tb_sentry_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sentry_boot_ctrl
// Self-checking bench for sentry_boot_ctrl. A behavioural AHB slave serves
// read data derived from the address, a reference model predicts the address
// sequence and the final verdict of each boot, and a monitor process compares
// what the controller presents against those predictions.
// -----------------------------------------------------------------------------
module tb_sentry_boot_ctrl;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LW  = 16;
  localparam int IW  = 32;
  localparam int TMO = 8;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [IW-1:0]    devid;
  logic             did_valid;
  logic [NR*AW-1:0] rgn_base;
  logic [NR*LW-1:0] rgn_words;
  logic [NR*DW-1:0] rgn_digest;
  logic             hclk_out;
  logic [AW-1:0]    haddr;
  logic [2:0]       hburst;
  logic             hmastlock;
  logic [3:0]       hprot;
  logic             hnonsec;
  logic [2:0]       hsize;
  logic [1:0]       htrans;
  logic [DW-1:0]    hwdata;
  logic             hwrite;
  logic [DW-1:0]    hrdata;
  logic             hready;
  logic             hresp;
  logic             done;
  logic             pass;
  logic [1:0]       fail_code;
  logic [3:0]       fail_region;

  typedef struct {
    logic       pass;
    logic [1:0] code;
    logic [3:0] region;
  } result_t;

  logic [31:0] exp_addr_q [$];
  result_t     exp_res_q  [$];

  // Boot configuration and bus behaviour for the current run.
  logic [31:0] cfg_base   [NR];
  int          cfg_words  [NR];
  logic [31:0] cfg_digest [NR];
  logic [31:0] cfg_devid;
  bit          err_en;
  logic [31:0] err_addr;
  bit          directed;
  logic [31:0] salt;
  int          wait_pct;
  bit          stall_all;
  bit          mon_en;

  // Slave-side view of the bus.
  bit          data_active;
  logic [31:0] data_addr;
  int          accepts;
  int          stall_run;

  int n_checks;
  int n_pass;

  sentry_boot_ctrl #(
    .NUM_REGIONS (NR),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .LEN_W       (LW),
    .DEVID_W     (IW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk_in                    (clk_in),
    .rst                       (rst),
    .I_did_hw_devid            (devid),
    .I_did_hw_valid            (did_valid),
    .I_rgn_base                (rgn_base),
    .I_rgn_words               (rgn_words),
    .I_rgn_digest              (rgn_digest),
    .sys_ctrl_hclk_out         (hclk_out),
    .sys_ctrl_haddr            (haddr),
    .sys_ctrl_hburst           (hburst),
    .sys_ctrl_hmastlock        (hmastlock),
    .sys_ctrl_hprot            (hprot),
    .sys_ctrl_hnonsec          (hnonsec),
    .sys_ctrl_hsize            (hsize),
    .sys_ctrl_htrans           (htrans),
    .sys_ctrl_hwdata           (hwdata),
    .sys_ctrl_hwrite           (hwrite),
    .sys_ctrl_hrdata           (hrdata),
    .sys_ctrl_hready           (hready),
    .sys_ctrl_hresp            (hresp),
    .O_sysctl_secure_boot_done (done),
    .O_sysctl_secure_boot_pass (pass),
    .O_sysctl_fail_code        (fail_code),
    .O_sysctl_fail_region      (fail_region)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_in = ~clk_in;

  // Memory contents as seen by the bus: fixed words for the directed case,
  // otherwise a salted hash of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (directed) begin
      if (a == 32'h0000_1000) return 32'h2;
      if (a == 32'h0000_1004) return 32'h4;
      return 32'h0;
    end
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return (x << 1) | (x >> 31);
  endfunction

  function automatic logic [31:0] goldenDigest(input int r);
    logic [31:0] a;
    a = cfg_devid;
    for (int w = 0; w < cfg_words[r]; w++) begin
      a = rotl1(a) ^ memWord(cfg_base[r] + 32'(4 * w));
    end
    return a;
  endfunction

  function automatic void pushResult(input logic p, input logic [1:0] c, input logic [3:0] r);
    result_t e;
    e.pass   = p;
    e.code   = c;
    e.region = r;
    exp_res_q.push_back(e);
  endfunction

  // Reference model: walk the regions in order, reading word by word, and
  // stop at the first bus error or digest mismatch.
  function automatic void modelRun();
    logic [31:0] a;
    logic [31:0] accum;
    for (int r = 0; r < NR; r++) begin
      accum = cfg_devid;
      for (int w = 0; w < cfg_words[r]; w++) begin
        a = cfg_base[r] + 32'(4 * w);
        exp_addr_q.push_back(a);
        if (err_en && (a == err_addr)) begin
          pushResult(1'b0, 2'b10, 4'(r));
          return;
        end
        accum = rotl1(accum) ^ memWord(a);
      end
      if (accum != cfg_digest[r]) begin
        pushResult(1'b0, 2'b01, 4'(r));
        return;
      end
    end
    pushResult(1'b1, 2'b00, 4'd0);
  endfunction

  task automatic flagFail(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act === exp) begin
      n_checks++;
      n_pass++;
    end else begin
      flagFail(name, act, exp);
    end
  endtask

  task automatic packCfg();
    for (int r = 0; r < NR; r++) begin
      rgn_base[r*AW +: AW]   = cfg_base[r];
      rgn_words[r*LW +: LW]  = LW'(cfg_words[r]);
      rgn_digest[r*DW +: DW] = cfg_digest[r];
    end
  endtask

  task automatic doReset();
    @(negedge clk_in);
    rst       = 1'b1;
    did_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_done"},        64'(done),        64'(0));
    checkOutput({tag, "_pass"},        64'(pass),        64'(0));
    checkOutput({tag, "_fail_code"},   64'(fail_code),   64'(0));
    checkOutput({tag, "_fail_region"}, 64'(fail_region), 64'(0));
    checkOutput({tag, "_htrans"},      64'(htrans),      64'(0));
    checkOutput({tag, "_haddr"},       64'(haddr),       64'(0));
  endtask

  task automatic pulseValid();
    @(negedge clk_in);
    devid     = cfg_devid;
    did_valid = 1'b1;
    @(posedge clk_in);
    #1;
    did_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cyc);
    cyc = 0;
    while (!done && (cyc < budget)) begin
      @(posedge clk_in);
      #1;
      cyc++;
    end
    if (!done) flagFail("done_wait_cycles", 64'(cyc), 64'(budget));
  endtask

  // One complete boot: optional reset, start pulse, wait for the verdict and
  // give the monitor time to consume the expected result.
  task automatic applyStimulus(input bit do_reset, input bit chk_lat, input int exp_cyc);
    int cyc;
    int w;
    packCfg();
    if (do_reset) doReset();
    accepts = 0;
    pulseValid();
    waitDone(3000, cyc);
    if (chk_lat) checkOutput("latency_cycles", 64'(cyc), 64'(exp_cyc));
    w = 0;
    while ((exp_res_q.size() != 0) && (w < 10)) begin
      @(posedge clk_in);
      w++;
    end
    if (exp_res_q.size() != 0) begin
      flagFail("result_not_presented", 64'(exp_res_q.size()), 64'(0));
      exp_res_q.delete();
      exp_addr_q.delete();
    end
  endtask

  task automatic setDirected(input logic [31:0] dig0);
    directed  = 1'b1;
    cfg_devid = 32'h1;
    cfg_base[0]   = 32'h0000_1000;
    cfg_words[0]  = 2;
    cfg_digest[0] = dig0;
    for (int r = 1; r < NR; r++) begin
      cfg_base[r]   = 32'h0000_8000 + 32'(r * 256);
      cfg_words[r]  = 0;
      cfg_digest[r] = 32'h1;
    end
    err_en   = 1'b0;
    wait_pct = 0;
  endtask

  // Behavioural AHB slave: at each falling edge decide hready/hresp/hrdata for
  // the coming rising edge, then track address and data phases.
  initial begin
    logic [1:0]  snap_trans;
    logic [31:0] snap_addr;
    hready      = 1'b1;
    hresp       = 1'b0;
    hrdata      = '0;
    data_active = 1'b0;
    data_addr   = '0;
    accepts     = 0;
    stall_run   = 0;
    forever begin
      @(negedge clk_in);
      if (data_active) begin
        hrdata = memWord(data_addr);
        hresp  = err_en && (data_addr == err_addr);
      end else begin
        hrdata = $urandom;
        hresp  = 1'b0;
      end
      if (stall_all) begin
        hready = 1'b0;
      end else if ((stall_run < 3) && ($urandom_range(0, 99) < wait_pct)) begin
        hready = 1'b0;
        stall_run++;
      end else begin
        hready    = 1'b1;
        stall_run = 0;
      end
      #1;
      snap_trans = htrans;
      snap_addr  = haddr;
      @(posedge clk_in);
      if (rst) begin
        data_active = 1'b0;
      end else if (data_active) begin
        if (hresp || hready) data_active = 1'b0;
      end else if ((snap_trans == 2'b10) && hready) begin
        data_active = 1'b1;
        data_addr   = snap_addr;
        accepts++;
      end
    end
  end

  // Monitor: every accepted address phase is checked against the predicted
  // address stream, and the rising edge of done against the predicted verdict.
  initial begin
    bit      done_seen;
    result_t e;
    done_seen = 1'b0;
    forever begin
      @(negedge clk_in);
      #2;
      if (!done) done_seen = 1'b0;
      if (mon_en && !rst) begin
        if ((htrans == 2'b10) && hready) begin
          if (exp_addr_q.size() == 0) flagFail("unexpected_transfer_haddr", 64'(haddr), 64'(0));
          else checkOutput("haddr", 64'(haddr), 64'(exp_addr_q.pop_front()));
        end
        if (done && !done_seen) begin
          done_seen = 1'b1;
          if (exp_res_q.size() == 0) begin
            flagFail("unexpected_done", 64'(done), 64'(0));
          end else begin
            e = exp_res_q.pop_front();
            checkOutput("pass",           64'(pass),              64'(e.pass));
            checkOutput("fail_code",      64'(fail_code),         64'(e.code));
            checkOutput("fail_region",    64'(fail_region),       64'(e.region));
            checkOutput("missing_xfers",  64'(exp_addr_q.size()), 64'(0));
            checkOutput("htrans_at_done", 64'(htrans),            64'(0));
          end
          exp_addr_q.delete();
        end
      end
    end
  end

  // Absolute limit on simulated time.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks so far %0d", n_checks);
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence.
  initial begin
    int cyc;
    int er;
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    devid      = '0;
    did_valid  = 1'b0;
    rgn_base   = '0;
    rgn_words  = '0;
    rgn_digest = '0;
    err_en     = 1'b0;
    err_addr   = '0;
    directed   = 1'b0;
    salt       = '0;
    wait_pct   = 0;
    stall_all  = 1'b0;
    mon_en     = 1'b1;
    cfg_devid  = '0;

    repeat (3) @(posedge clk_in);
    #1;
    checkResetValues("por");
    checkOutput("hsize",  64'(hsize),  64'(2));
    checkOutput("hburst", 64'(hburst), 64'(0));
    checkOutput("hprot",  64'(hprot),  64'(3));
    checkOutput("hwrite", 64'(hwrite), 64'(0));
    rst = 1'b0;

    // Region 0 reads 2 then 4: seed 1 -> 0 -> 4, matching digest 4.
    // Regions 1..3 are empty with digest equal to the device ID.
    $display("[TB] directed pass");
    setDirected(32'h4);
    exp_addr_q.push_back(32'h0000_1000);
    exp_addr_q.push_back(32'h0000_1004);
    pushResult(1'b1, 2'b00, 4'd0);
    applyStimulus(1'b1, 1'b1, 2 * 2 + NR);

    $display("[TB] directed digest mismatch");
    setDirected(32'h5);
    exp_addr_q.push_back(32'h0000_1000);
    exp_addr_q.push_back(32'h0000_1004);
    pushResult(1'b0, 2'b01, 4'd0);
    applyStimulus(1'b1, 1'b1, 2 * 2 + 1);

    // Bus error on the second read of region 1.
    $display("[TB] bus error in region 1");
    directed  = 1'b0;
    salt      = $urandom;
    cfg_devid = $urandom;
    for (int r = 0; r < NR; r++) begin
      cfg_base[r]  = 32'h0000_2000 + 32'(r * 256);
      cfg_words[r] = 3;
    end
    for (int r = 0; r < NR; r++) cfg_digest[r] = goldenDigest(r);
    err_en   = 1'b1;
    err_addr = cfg_base[1] + 32'h4;
    wait_pct = 20;
    modelRun();
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("bus_err_region", 64'(fail_region), 64'(1));
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("bus_err_htrans_after", 64'(htrans), 64'(0));

    // Address increment wraps at the top of the address space.
    $display("[TB] address wrap");
    salt      = $urandom;
    cfg_devid = $urandom;
    for (int r = 0; r < NR; r++) begin
      cfg_base[r]  = $urandom & 32'hFFFF_FFFC;
      cfg_words[r] = $urandom_range(0, 2);
    end
    cfg_base[0]  = 32'hFFFF_FFF8;
    cfg_words[0] = 4;
    for (int r = 0; r < NR; r++) cfg_digest[r] = goldenDigest(r);
    err_en   = 1'b0;
    wait_pct = 10;
    modelRun();
    applyStimulus(1'b1, 1'b0, 0);

    // A slave that never becomes ready.
    $display("[TB] permanent wait states");
    for (int r = 0; r < NR; r++) begin
      cfg_base[r]  = 32'h0000_4000 + 32'(r * 64);
      cfg_words[r] = (r == 0) ? 1 : 0;
    end
    for (int r = 0; r < NR; r++) cfg_digest[r] = goldenDigest(r);
    stall_all = 1'b1;
    packCfg();
    doReset();
`ifdef SENTRY_BOOT_TIMEOUT_EN
    pushResult(1'b0, 2'b11, 4'd0);
    pulseValid();
    waitDone(200, cyc);
    checkOutput("timeout_cycles", 64'(cyc), 64'(TMO));
    repeat (2) @(posedge clk_in);
    if (exp_res_q.size() != 0) flagFail("timeout_result_not_presented", 64'(exp_res_q.size()), 64'(0));
    exp_res_q.delete();
`else
    pulseValid();
    repeat (100) @(posedge clk_in);
    #1;
    checkOutput("stall_done",   64'(done),   64'(0));
    checkOutput("stall_htrans", 64'(htrans), 64'(2));
    checkOutput("stall_haddr",  64'(haddr),  64'(32'h0000_4000));
    checkOutput("stall_code",   64'(fail_code), 64'(0));
`endif
    stall_all = 1'b0;

    // Randomised boots: region layout, lengths, digests, errors, wait states.
    for (int run = 0; run < 24; run++) begin
      directed  = 1'b0;
      salt      = $urandom;
      cfg_devid = $urandom;
      for (int r = 0; r < NR; r++) begin
        cfg_base[r]  = $urandom & 32'hFFFF_FFFC;
        cfg_words[r] = $urandom_range(0, 4);
      end
      for (int r = 0; r < NR; r++) cfg_digest[r] = goldenDigest(r);
      if ($urandom_range(0, 3) == 0) begin
        er = $urandom_range(0, NR - 1);
        cfg_digest[er] = cfg_digest[er] ^ (32'h1 << $urandom_range(0, 31));
      end
      err_en = 1'b0;
      if ($urandom_range(0, 4) == 0) begin
        er = $urandom_range(0, NR - 1);
        if (cfg_words[er] > 0) begin
          err_en   = 1'b1;
          err_addr = cfg_base[er] + 32'(4 * $urandom_range(0, cfg_words[er] - 1));
        end
      end
      wait_pct = $urandom_range(0, 40);
      modelRun();
      applyStimulus(1'b1, 1'b0, 0);
    end

    // Reset during a data phase of region 2, then restart without another
    // reset and expect a full boot from region 0.
    $display("[TB] reset mid-transfer and restart");
    salt      = $urandom;
    cfg_devid = $urandom;
    for (int r = 0; r < NR; r++) begin
      cfg_base[r]  = 32'h0000_3000 + 32'(r * 64);
      cfg_words[r] = 2;
    end
    for (int r = 0; r < NR; r++) cfg_digest[r] = goldenDigest(r);
    err_en   = 1'b0;
    wait_pct = 20;
    mon_en   = 1'b0;
    packCfg();
    doReset();
    accepts = 0;
    pulseValid();
    cyc = 0;
    while (!((accepts >= cfg_words[0] + cfg_words[1] + 1) && data_active) && (cyc < 500)) begin
      @(posedge clk_in);
      #1;
      cyc++;
    end
    if (cyc >= 500) flagFail("reach_region2_data_cycles", 64'(cyc), 64'(500));
    checkOutput("mid_haddr_region2", 64'(data_addr), 64'(cfg_base[2]));
    @(negedge clk_in);
    rst = 1'b1;
    @(posedge clk_in);
    #1;
    checkResetValues("mid_rst");
    @(negedge clk_in);
    rst    = 1'b0;
    mon_en = 1'b1;
    modelRun();
    applyStimulus(1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sentry_boot_ctrl.md
SENTRY_BOOT_CTRL -- requirements
Module: sentry_boot_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 4: number of boot regions measured, 1..16.
REQ-002 SHALL have parameter ADDR_W, default 32: AHB address width.
REQ-003 SHALL have parameter DATA_W, default 32: AHB data and digest width, one of 32 or 64.
REQ-004 SHALL have parameter LEN_W, default 16: region word-count width.
REQ-005 SHALL have parameter DEVID_W, default 32: device ID width.
REQ-006 SHALL have parameter TIMEOUT_CYC, default 1024: maximum wait-state cycles per transfer.
REQ-007 SHALL use one clock and a synchronous, active-high reset:
- clk_in  in  1  clock
- rst  in  1  synchronous active-high reset
- I_did_hw_devid  in  DEVID_W  device ID
- I_did_hw_valid  in  1  device ID valid; start trigger
- I_rgn_base  in  NUM_REGIONS*ADDR_W  region base byte addresses, region i at slice i
- I_rgn_words  in  NUM_REGIONS*LEN_W  region lengths in words
- I_rgn_digest  in  NUM_REGIONS*DATA_W  expected region digests
- sys_ctrl_hclk_out  out  1  equals clk_in
- sys_ctrl_haddr  out  ADDR_W  address
- sys_ctrl_hburst, hmastlock, hprot, hnonsec, hsize, htrans, hwdata, hwrite  out  3/1/4/1/3/2/DATA_W/1  AHB-Lite controls
- sys_ctrl_hrdata  in  DATA_W; sys_ctrl_hready  in  1; sys_ctrl_hresp  in  1
- O_sysctl_secure_boot_done  out  1  measurement finished, sticky
- O_sysctl_secure_boot_pass  out  1  all regions matched, sticky
- O_sysctl_fail_code  out  2  00 none, 01 digest mismatch, 10 bus error, 11 timeout
- O_sysctl_fail_region  out  4  index of failing region

Function
REQ-008 SHALL drive constants: hburst SINGLE, hsize log2(DATA_W/8), hprot 4'b0011, hwrite 0, hwdata 0, hmastlock 0, hnonsec 0.
REQ-009 SHALL implement FSM IDLE, ADDR, DATA, CHECK, DONE, FAIL.
REQ-010 IDLE: on I_did_hw_valid=1, latch devid, set region=0, go to ADDR; if I_rgn_words of the current region is 0, go to CHECK instead.
REQ-011 ADDR: htrans=NONSEQ and haddr=current address; on hready=1, go to DATA.
REQ-012 DATA: htrans=IDLE; on hready=1 and hresp=0, update the accumulator, increment the address by DATA_W/8 (modulo 2^ADDR_W), decrement the word count, then go to ADDR or, at count 0, to CHECK.
REQ-013 Accumulator SHALL be seeded per region with the latched devid (zero-extended or truncated to DATA_W); update = rotate-left-by-1(acc) XOR hrdata.
REQ-014 CHECK: one cycle; compare acc with the region digest; on match go to the next region (ADDR, or CHECK if its length is 0) or, after the last region, go to DONE with pass=1; on mismatch go to FAIL with code 01.
REQ-015 hresp=1 in DATA SHALL go to FAIL with code 10 on that cycle, regardless of hready.
REQ-016 DONE/FAIL SHALL be terminal until reset; done=1 in both; fail_region = region index at failure.
REQ-017 I_did_hw_valid SHALL be ignored outside IDLE; region inputs SHALL be held stable by the system while not in IDLE.
REQ-018 Per-word latency SHALL be 2 cycles with zero wait states; CHECK SHALL add 1 cycle per region.

Reset
REQ-019 rst=1 SHALL force IDLE, htrans IDLE, haddr 0, done/pass 0, fail_code 00, fail_region 0, all internal counters 0, on the next clk_in edge, including mid-transfer.

Configuration
REQ-020 With SENTRY_BOOT_TIMEOUT_EN defined, a counter SHALL count consecutive hready=0 cycles in ADDR/DATA and go to FAIL with code 11 when the count reaches TIMEOUT_CYC; the counter SHALL clear on hready=1.
REQ-021 Without SENTRY_BOOT_TIMEOUT_EN, no counter SHALL be present and code 11 SHALL be never produced.

Structure
REQ-022 State encoding, fail-code constants and the HTRANS/HBURST/HPROT constants SHALL live in shared package sentry_pkg.
REQ-023 The digest datapath (seed, rotate-XOR, compare) SHALL be sub-module sentry_digest_acc.

Verification
REQ-024 devid=0x1; region0 base 0x1000, words 2, digest 0x4; reads 0x2, 0x4; zero wait states -> haddr 0x1000, 0x1004; done=1, pass=1, fail_code 00.
REQ-025 Same as REQ-024 with digest 0x5 -> done=1, pass=0, fail_code 01, fail_region 0.
REQ-026 Region1 of 4, second read returns hresp=1 -> FAIL next edge, fail_code 10, fail_region 1, htrans IDLE thereafter.
REQ-027 Region with words=0 and digest=devid -> no bus transfer for that region; passes CHECK.
REQ-028 With SENTRY_BOOT_TIMEOUT_EN and TIMEOUT_CYC=8, hready held 0 -> fail_code 11 after 8 cycles; without the macro -> waits indefinitely.
REQ-029 rst asserted in DATA of region 2 -> all outputs at reset values next edge; a new valid pulse restarts from region 0, base address.
